// File: rtl/rst_seq_ctrl.sv
// Consumer-side reset sequencer: asserts all reset outputs asynchronously, then
// releases them one stage at a time. Software resets use a four-phase req/ack handshake.
module rst_seq_ctrl #(
  parameter int NUM_STAGES  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 16,
  parameter int STAGE_DLY   = 1000,
  parameter int CNT_W       = 20
) (
  input  logic                  sys_clk_i,
  input  logic                  hw_arst_i,
  input  logic                  sw_rst_req_i,
  output logic                  sw_rst_ack_o,
  output logic [NUM_STAGES-1:0] rst_n_o,
  output logic                  busy_o,
  output logic [1:0]            state_o
);
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0] STRETCH_END = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0] DLY_END     = CNT_W'(STAGE_DLY - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_ACK     = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  sw_flag_q, sw_flag_d;
  logic                  ack_q, ack_d;
  logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;

  logic [SYNC_STAGES-1:0] hw_sync;
  logic                   hw_hold;
  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_prev;
  logic                   req_lvl;
  logic                   req_rise;

  // hw release synchronizer; the extra hold flop makes the first counting edge
  // of a hw sequence line up with the first counting edge of a sw sequence.
  always_ff @(posedge sys_clk_i or posedge hw_arst_i) begin
    if (hw_arst_i) begin
      hw_sync <= '1;
      hw_hold <= 1'b1;
    end else begin
      hw_sync <= {hw_sync[SYNC_STAGES-2:0], 1'b0};
      hw_hold <= hw_sync[SYNC_STAGES-1];
    end
  end

  // sw request synchronizer and rising-edge detector
  always_ff @(posedge sys_clk_i or posedge hw_arst_i) begin
    if (hw_arst_i) begin
      req_sync <= '0;
      req_prev <= 1'b0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], sw_rst_req_i};
      req_prev <= req_sync[SYNC_STAGES-1];
    end
  end

  assign req_lvl  = req_sync[SYNC_STAGES-1];
  assign req_rise = req_lvl & ~req_prev;

  always_ff @(posedge sys_clk_i or posedge hw_arst_i) begin
    if (hw_arst_i) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      idx_q     <= '0;
      sw_flag_q <= 1'b0;
      ack_q     <= 1'b0;
      rst_n_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sw_flag_q <= sw_flag_d;
      ack_q     <= ack_d;
      rst_n_q   <= rst_n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    sw_flag_d = sw_flag_q;
    ack_d     = ack_q;
    rst_n_d   = rst_n_q;
    case (state_q)
      ST_ASSERT: begin
        rst_n_d = '0;
        if (hw_hold) begin
          cnt_d = '0;
        end else if (cnt_q == STRETCH_END) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (cnt_q == DLY_END) begin
          rst_n_d[idx_q] = 1'b1;
          cnt_d          = '0;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = sw_flag_q ? ST_ACK : ST_RUN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ACK: begin
        if (!req_lvl) begin
          ack_d     = 1'b0;
          sw_flag_d = 1'b0;
          state_d   = ST_RUN;
        end else begin
          ack_d = 1'b1;
        end
      end
      ST_RUN: begin
        rst_n_d = '1;
        if (req_rise) begin
          sw_flag_d = 1'b1;
          rst_n_d   = '0;
          cnt_d     = '0;
          state_d   = ST_ASSERT;
        end
      end
      default: state_d = ST_ASSERT;
    endcase
  end

  assign rst_n_o      = rst_n_q;
  assign busy_o       = ~&rst_n_q;
  assign sw_rst_ack_o = ack_q;
  assign state_o      = state_q;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: release times come from a timeline model that derives
// each bit's release edge from STRETCH and STAGE_DLY, with randomized stimulus timing.
module tb_rst_seq_ctrl;
  localparam int ST  = 4;
  localparam int DLY = 8;
  localparam int L   = ST + 3 * DLY;

  logic       clk = 1'b0;
  logic       hw  = 1'b0;
  logic       req = 1'b0;
  logic       ack;
  logic [2:0] rst_n;
  logic       busy;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  rst_seq_ctrl #(
    .NUM_STAGES (3),
    .SYNC_STAGES(2),
    .STRETCH    (ST),
    .STAGE_DLY  (DLY),
    .CNT_W      (8)
  ) dut (
    .sys_clk_i   (clk),
    .hw_arst_i   (hw),
    .sw_rst_req_i(req),
    .sw_rst_ack_o(ack),
    .rst_n_o     (rst_n),
    .busy_o      (busy),
    .state_o     (state)
  );

  always #5 clk = ~clk;

  // k = edges since the sequence's assertion edge; bit j is released
  // STRETCH + (j+1)*STAGE_DLY edges after it.
  function automatic logic [2:0] exp_rst(input int k);
    logic [2:0] r;
    r = '0;
    for (int j = 0; j < 3; j++)
      if (k >= ST + (j + 1) * DLY) r[j] = 1'b1;
    return r;
  endfunction

  function automatic logic [1:0] exp_state(input int k, input bit sw);
    if (k < ST) return 2'd0;
    if (k < L)  return 2'd1;
    return sw ? 2'd2 : 2'd3;
  endfunction

  task automatic test_reset();
    #1 hw = 1'b1;
    #2;
    total++;
    if (rst_n !== 3'b000 || busy !== 1'b1 || ack !== 1'b0 || state !== 2'd0) begin
      bad++;
      $display("FAIL reset_async rst_n=%b busy=%b ack=%b state=%0d want 000/1/0/0", rst_n, busy, ack, state);
    end
    repeat (3) @(negedge clk);
    total++;
    if (rst_n !== 3'b000 || busy !== 1'b1 || ack !== 1'b0 || state !== 2'd0) begin
      bad++;
      $display("FAIL reset_hold rst_n=%b busy=%b ack=%b state=%0d want 000/1/0/0", rst_n, busy, ack, state);
    end
  endtask

  // Releases hw at a negedge (E0 is the next posedge) and checks every cycle
  // against the hw timeline: assertion edge is E0+2. Optional req pulse.
  task automatic test_power_up(input int pulse_at, input int pulse_len);
    logic [2:0] e;
    logic [1:0] es;
    @(negedge clk);
    hw = 1'b0;
    for (int m = 0; m <= L + 8; m++) begin
      @(negedge clk);
      e  = exp_rst(m - 2);
      es = exp_state(m - 2, 1'b0);
      total++;
      if (rst_n !== e || busy !== ~&e || ack !== 1'b0 || state !== es) begin
        bad++;
        $display("FAIL pwr_seq E0+%0d rst_n=%b busy=%b ack=%b state=%0d want %b/%b/0/%0d",
                 m, rst_n, busy, ack, state, e, ~&e, es);
      end
      if (m == pulse_at) req = 1'b1;
      if (m == pulse_at + pulse_len) req = 1'b0;
    end
  endtask

  task automatic test_sw_reset();
    int n;
    int hold;
    logic [2:0] e;
    repeat ($urandom_range(1, 5)) @(negedge clk);
    req = 1'b1;
    n = 0;
    while (rst_n !== 3'b000 && n < 4) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (rst_n !== 3'b000 || busy !== 1'b1 || state !== 2'd0) begin
      bad++;
      $display("FAIL sw_assert rst_n=%b busy=%b state=%0d want 000/1/0 within 4 edges", rst_n, busy, state);
    end
    for (int k = 1; k <= L + 1; k++) begin
      @(negedge clk);
      e = exp_rst(k);
      total++;
      if (rst_n !== e || busy !== ~&e || state !== exp_state(k, 1'b1) || ack !== logic'(k > L)) begin
        bad++;
        $display("FAIL sw_seq A+%0d rst_n=%b busy=%b state=%0d ack=%b want %b/%b/%0d/%b",
                 k, rst_n, busy, state, ack, e, ~&e, exp_state(k, 1'b1), logic'(k > L));
      end
    end
    hold = $urandom_range(0, 3);
    repeat (hold) begin
      @(negedge clk);
      total++;
      if (ack !== 1'b1 || state !== 2'd2 || rst_n !== 3'b111) begin
        bad++;
        $display("FAIL sw_ack_hold ack=%b state=%0d rst_n=%b want 1/2/111", ack, state, rst_n);
      end
    end
    req = 1'b0;
    n = 0;
    while (ack !== 1'b0 && n < 3) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (ack !== 1'b0 || state !== 2'd3 || rst_n !== 3'b111 || busy !== 1'b0) begin
      bad++;
      $display("FAIL sw_ack_fall ack=%b state=%0d rst_n=%b busy=%b want 0/3/111/0 within 3 edges",
               ack, state, rst_n, busy);
    end
  endtask

  task automatic test_held_req();
    @(negedge clk);
    #2 hw = 1'b1;
    @(negedge clk);
    req = 1'b1;
    repeat (3) @(negedge clk);
    test_power_up(-1, 0);
    req = 1'b0;
    repeat (4) @(negedge clk);
    test_sw_reset();
  endtask

  task automatic test_abort();
    int cut;
    logic [2:0] e;
    @(negedge clk);
    #2 hw = 1'b1;
    repeat (2) @(negedge clk);
    hw = 1'b0;
    cut = $urandom_range(14, 28);
    for (int m = 0; m <= cut; m++) begin
      @(negedge clk);
      e = exp_rst(m - 2);
      total++;
      if (rst_n !== e) begin
        bad++;
        $display("FAIL abort_pre E0+%0d rst_n=%b want %b", m, rst_n, e);
      end
    end
    #2 hw = 1'b1;
    #1;
    total++;
    if (rst_n !== 3'b000 || busy !== 1'b1 || ack !== 1'b0 || state !== 2'd0) begin
      bad++;
      $display("FAIL abort_now rst_n=%b busy=%b ack=%b state=%0d want 000/1/0/0", rst_n, busy, ack, state);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      total++;
      if (rst_n !== 3'b000 || state !== 2'd0) begin
        bad++;
        $display("FAIL abort_hold rst_n=%b state=%0d want 000/0", rst_n, state);
      end
    end
    test_power_up(-1, 0);
  endtask

  task automatic test_abort_ack();
    int w;
    @(negedge clk);
    req = 1'b1;
    w = 0;
    while (!(ack === 1'b1 && state === 2'd2) && w < 50) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (ack !== 1'b1 || state !== 2'd2) begin
      bad++;
      $display("FAIL ack_reach ack=%b state=%0d want 1/2 within 50 cycles", ack, state);
    end
    #2 hw = 1'b1;
    #1;
    total++;
    if (ack !== 1'b0 || rst_n !== 3'b000 || state !== 2'd0) begin
      bad++;
      $display("FAIL ack_abort ack=%b rst_n=%b state=%0d want 0/000/0", ack, rst_n, state);
    end
    repeat (2) @(negedge clk);
    test_power_up(-1, 0);
    req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_dropped_req();
    int at;
    int len;
    at  = $urandom_range(8, 20);
    len = $urandom_range(1, 4);
    @(negedge clk);
    #2 hw = 1'b1;
    repeat (2) @(negedge clk);
    test_power_up(at, len);
  endtask

  initial begin
    test_reset();
    test_power_up(-1, 0);
    test_sw_reset();
    test_sw_reset();
    test_held_req();
    test_abort();
    test_abort_ack();
    test_dropped_req();
    test_sw_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
